traffic_light_fsm: RTL and testbench
====================================

# traffic_light_fsm

Two-street intersection controller: a Moore FSM drives the light colours for street A (`la`) and street B (`lb`) from the traffic sensors `ta` and `tb`. A street keeps green while its sensor reports traffic. When its traffic clears, the street passes through yellow to red and the other street gets green. It is a standalone leaf block clocked by the system clock.

## Interface
- `YELLOW_CYCLES`, default 1: number of clock cycles a yellow phase lasts; legal values ≥ 1.
- `MIN_GREEN_CYCLES`, default 1: minimum number of cycles a green phase lasts before it may end; legal values ≥ 1.
- `clk`, input, 1 bit: single clock; all state changes on the rising edge.
- `reset`, input, 1 bit: synchronous, active-high reset.
- `ta`, input, 1 bit: traffic present on street A (1 = cars waiting or passing).
- `tb`, input, 1 bit: traffic present on street B.
- `la`, output, 2 bits: street A light colour.
- `lb`, output, 2 bits: street B light colour.

## Operation
- Colour encoding: GREEN = 2'b00, YELLOW = 2'b01, RED = 2'b10. 2'b11 is never driven.
- States and Moore outputs:
  - S0: `la` = GREEN, `lb` = RED.
  - S1: `la` = YELLOW, `lb` = RED.
  - S2: `la` = RED, `lb` = GREEN.
  - S3: `la` = RED, `lb` = YELLOW.
- Outputs decode only from the state register, never combinationally from `ta`/`tb`.
- Phase timer: a saturating cycle counter.
  - Cleared to 0 on every state transition and on reset.
  - Otherwise incremented each cycle, saturating at max(`YELLOW_CYCLES`, `MIN_GREEN_CYCLES`) − 1.
  - Width is $clog2 of that maximum, minimum 1 bit.
- Transitions, evaluated at each rising edge:
  - S0 → S1 when `ta` = 0 and timer ≥ `MIN_GREEN_CYCLES` − 1; otherwise stay in S0.
  - S1 → S2 when timer = `YELLOW_CYCLES` − 1; otherwise stay in S1. `ta`/`tb` are ignored.
  - S2 → S3 when `tb` = 0 and timer ≥ `MIN_GREEN_CYCLES` − 1; otherwise stay in S2.
  - S3 → S0 when timer = `YELLOW_CYCLES` − 1; otherwise stay in S3.
- With default parameters, each yellow phase is exactly one cycle and a green phase ends on the first edge at which its sensor reads 0.
- `ta` = `tb` = 1 simultaneously: the current green street keeps green indefinitely; there is no starvation arbitration.
- The red street's sensor never affects the transition out of the current green phase.
- Unreachable state encodings recover to S0 on the next edge.

## Timing
- `reset` high at a rising edge sets state to S0 and the timer to 0, so `la` = 00 and `lb` = 10 after that edge. Reset has priority over all transitions, including mid-yellow.
- Before the first reset edge, outputs are undefined.
- Sensors are sampled only at the rising edge. Outputs change only after the edge, with one-edge latency from a sensor change to the colour change.
- Default full cycle with no traffic: S0 → S1 → S2 → S3 → S0, one state per edge, 4-cycle period.

## Test plan
- Reset then hold `ta` = `tb` = 0, defaults → successive edges give (`la`, `lb`) = (00,10), (01,10), (10,00), (10,01), (00,10).
- From S0, hold `ta` = 1 for 5 edges → stays (00,10). Drop `ta` → (01,10) after the next edge, (10,00) one edge later.
- From S2, hold `tb` = 1 with `ta` toggling → stays (10,00). Drop `tb` → (10,01), then (00,10).
- Assert `reset` while in S1 or S3 → (00,10) after that edge. Deassert with `ta` = 0 → S1 on the following edge.
- Stimulus sequence from reset, edge every 10 time units, 1 = 10-time-unit interval:
  - Stimulus: `ta`/`tb` = 0/0 for 2 intervals, 1/0 for 2, 0/1 for 2, 0/0 for 2.
  - Required (`la`, `lb`) sequence: (00,10), (01,10), (10,00), (10,01), (00,10), (01,10), (10,00), (10,01), (00,10).
- `YELLOW_CYCLES` = 3, `MIN_GREEN_CYCLES` = 4, sensors 0 → S0 lasts 4 cycles, S1 3, S2 4, S3 3. `ta` = 1 held past the minimum extends S0.

Source files
------------

// File: rtl/traffic_light_fsm.sv
`default_nettype none
//==============================================================================
// Module      : traffic_light_fsm
// Description : Two-street intersection controller. A Moore FSM drives the
//               light colours of street A (la) and street B (lb) from the
//               traffic sensors ta and tb. A street keeps green while its
//               sensor reports traffic (after a minimum green time). Once its
//               traffic clears, it passes through yellow to red and the other
//               street gets green.
//
// Parameters  : YELLOW_CYCLES    - cycles a yellow phase lasts (>= 1)
//               MIN_GREEN_CYCLES - minimum cycles of a green phase (>= 1)
//
// Ports       : clk   - system clock, rising-edge active
//               reset - synchronous, active-high reset (state -> S0)
//               ta    - traffic present on street A
//               tb    - traffic present on street B
//               la    - street A colour (00 green, 01 yellow, 10 red)
//               lb    - street B colour (00 green, 01 yellow, 10 red)
//
// Revision    : 1.0 - initial release
//==============================================================================
module traffic_light_fsm #(
   parameter int YELLOW_CYCLES    = 1,
   parameter int MIN_GREEN_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ta,
   input  logic       tb,
   output logic [1:0] la,
   output logic [1:0] lb
);

   // Longest phase length the timer must be able to count through.
   localparam int c_max_cycles = (YELLOW_CYCLES > MIN_GREEN_CYCLES) ?
                                 YELLOW_CYCLES : MIN_GREEN_CYCLES;
   localparam int c_tw         = (c_max_cycles > 1) ? $clog2(c_max_cycles) : 1;

   localparam logic [c_tw-1:0] c_timer_sat  = c_tw'(c_max_cycles - 1);
   localparam logic [c_tw-1:0] c_yellow_end = c_tw'(YELLOW_CYCLES - 1);
   localparam logic [c_tw-1:0] c_green_min  = c_tw'(MIN_GREEN_CYCLES - 1);

   localparam logic [1:0] c_green  = 2'b00;
   localparam logic [1:0] c_yellow = 2'b01;
   localparam logic [1:0] c_red    = 2'b10;

   typedef enum logic [1:0] {
      S0 = 2'b00,   // A green,  B red
      S1 = 2'b01,   // A yellow, B red
      S2 = 2'b10,   // A red,    B green
      S3 = 2'b11    // A red,    B yellow
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [c_tw-1:0]   r_timer;

   //---------------------------------------------------------------------------
   // State register and phase timer. The timer restarts at every state
   // change so it always measures time spent in the current phase; it
   // saturates so a long green never wraps back below the minimum.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S0;
         r_timer <= '0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state) begin
            r_timer <= '0;
         end else if (r_timer != c_timer_sat) begin
            r_timer <= r_timer + 1'b1;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Next-state logic. Only the green street's own sensor can end its green
   // phase; yellow phases are purely timed.
   //---------------------------------------------------------------------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         S0: if (!ta && (r_timer >= c_green_min))  w_next = S1;
         S1: if (r_timer == c_yellow_end)          w_next = S2;
         S2: if (!tb && (r_timer >= c_green_min))  w_next = S3;
         S3: if (r_timer == c_yellow_end)          w_next = S0;
         default:                                  w_next = S0;
      endcase
   end

   //---------------------------------------------------------------------------
   // Moore output decode from the state register only.
   //---------------------------------------------------------------------------
   always_comb begin
      la = c_green;
      lb = c_red;
      case (r_state)
         S0: begin la = c_green;  lb = c_red;    end
         S1: begin la = c_yellow; lb = c_red;    end
         S2: begin la = c_red;    lb = c_green;  end
         S3: begin la = c_red;    lb = c_yellow; end
         default: begin la = c_green; lb = c_red; end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_fsm.sv
`default_nettype none
//==============================================================================
// Module      : tb_traffic_light_fsm
// Description : Self-checking bench for traffic_light_fsm. Drives two
//               instances (default parameters, and YELLOW_CYCLES=3 /
//               MIN_GREEN_CYCLES=4) with the same stimulus and compares both
//               against a phase/elapsed-cycle reference model every cycle.
//               A few hand-computed sequences pin the model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_traffic_light_fsm;

   logic       clk;
   logic       reset;
   logic       ta;
   logic       tb;
   logic [1:0] la0, lb0, la1, lb1;

   int checks = 0;
   int errors = 0;

   traffic_light_fsm u_dut0 (
      .clk   (clk),
      .reset (reset),
      .ta    (ta),
      .tb    (tb),
      .la    (la0),
      .lb    (lb0)
   );

   traffic_light_fsm #(
      .YELLOW_CYCLES    (3),
      .MIN_GREEN_CYCLES (4)
   ) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .ta    (ta),
      .tb    (tb),
      .la    (la1),
      .lb    (lb1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   //---------------------------------------------------------------------------
   // Reference model: phase 0..3 = A green, A yellow, B green, B yellow;
   // m_n = number of cycles spent in the current phase including this one.
   //---------------------------------------------------------------------------
   int c_yel[2] = '{1, 3};
   int c_grn[2] = '{1, 4};
   int m_phase[2];
   int m_n[2];
   bit m_valid = 1'b0;

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         automatic int  p    = m_phase[i];
         automatic int  n    = m_n[i];
         automatic bit  adv  = 1'b0;
         automatic logic sens = (p == 0) ? ta : tb;
         if (reset) begin
            m_phase[i] <= 0;
            m_n[i]     <= 1;
         end else begin
            if (p == 0 || p == 2) adv = (sens == 1'b0) && (n >= c_grn[i]);
            else                  adv = (n >= c_yel[i]);
            if (adv) begin
               m_phase[i] <= (p + 1) % 4;
               m_n[i]     <= 1;
            end else begin
               m_n[i]     <= n + 1;
            end
         end
      end
      if (reset) m_valid <= 1'b1;
   end

   function automatic logic [1:0] exp_la(input int p);
      return (p == 0) ? 2'b00 : (p == 1) ? 2'b01 : 2'b10;
   endfunction

   function automatic logic [1:0] exp_lb(input int p);
      return (p == 2) ? 2'b00 : (p == 3) ? 2'b01 : 2'b10;
   endfunction

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Per-cycle model comparison, away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_la0", la0, exp_la(m_phase[0]));
         chk("model_lb0", lb0, exp_lb(m_phase[0]));
         chk("model_la1", la1, exp_la(m_phase[1]));
         chk("model_lb1", lb1, exp_lb(m_phase[1]));
      end
   end

   //---------------------------------------------------------------------------
   // Stimulus with literal expectations, then randomized traffic.
   //---------------------------------------------------------------------------
   initial begin
      logic [1:0] la0_seq [4];
      logic [1:0] lb0_seq [4];
      logic [1:0] e_la1, e_lb1;
      la0_seq = '{2'b00, 2'b01, 2'b10, 2'b10};
      lb0_seq = '{2'b10, 2'b10, 2'b00, 2'b01};

      reset = 1'b1;
      ta    = 1'b0;
      tb    = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // No traffic: default period 4; slow instance S0 4, S1 3, S2 4, S3 3.
      for (int k = 0; k < 15; k++) begin
         chk("idle_la0", la0, la0_seq[k % 4]);
         chk("idle_lb0", lb0, lb0_seq[k % 4]);
         if      (k < 4)  begin e_la1 = 2'b00; e_lb1 = 2'b10; end
         else if (k < 7)  begin e_la1 = 2'b01; e_lb1 = 2'b10; end
         else if (k < 11) begin e_la1 = 2'b10; e_lb1 = 2'b00; end
         else if (k < 14) begin e_la1 = 2'b10; e_lb1 = 2'b01; end
         else             begin e_la1 = 2'b00; e_lb1 = 2'b10; end
         chk("idle_la1", la1, e_la1);
         chk("idle_lb1", lb1, e_lb1);
         @(negedge clk);
      end

      // Street A busy for 5 edges holds green, then yellow, then red.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      ta    = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("hold_a_la0", la0, 2'b00);
      end
      ta = 1'b0;
      @(negedge clk);
      chk("drop_a_la0", la0, 2'b01);
      @(negedge clk);
      chk("drop_a_la0_red", la0, 2'b10);
      chk("drop_a_lb0_grn", lb0, 2'b00);

      // Street B busy with A toggling keeps B green.
      tb = 1'b1;
      repeat (4) begin
         ta = ~ta;
         @(negedge clk);
         chk("hold_b_lb0", lb0, 2'b00);
      end
      tb = 1'b0;
      ta = 1'b0;
      @(negedge clk);
      chk("drop_b_lb0", lb0, 2'b01);
      @(negedge clk);
      chk("drop_b_la0", la0, 2'b00);
      // Now in S1 for default instance: reset mid-yellow.
      @(negedge clk);
      chk("yellow_la0", la0, 2'b01);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_yel_la0", la0, 2'b00);
      chk("rst_yel_lb0", lb0, 2'b10);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_la0", la0, 2'b01);

      // Randomized traffic with occasional resets; per-segment sensor bias.
      for (int seg = 0; seg < 40; seg++) begin
         automatic int bias = $urandom_range(0, 3);
         for (int c = 0; c < 75; c++) begin
            ta    = ($urandom_range(0, 3) < bias) ? 1'b1 : 1'b0;
            tb    = ($urandom_range(0, 3) < bias) ? 1'b1 : 1'b0;
            reset = ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
         end
      end
      reset = 1'b0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
